// File: rtl/full_subtractor_if.sv
// Operand/result bundle for the registered ripple-borrow subtractor.
// Carries minuend, subtrahend, borrow-in with their valid, and the registered result.
// The producer drives the master side; the subtractor sits on the slave side.
interface full_subtractor_if #(
   parameter int WIDTH = 1
);
   logic             in_valid;
   logic [WIDTH-1:0] X;
   logic [WIDTH-1:0] Y;
   logic             Z;
   logic             out_valid;
   logic [WIDTH-1:0] Diff;
   logic             Borr;

   modport master (
      output in_valid, X, Y, Z,
      input  out_valid, Diff, Borr
   );

   modport slave (
      input  in_valid, X, Y, Z,
      output out_valid, Diff, Borr
   );
endinterface

// File: rtl/full_subtractor.sv
// Registered N-bit ripple-borrow subtractor: {Borr, Diff} = X - Y - Z, built from 1-bit cells.
// Latency: exactly 1 cycle from an accepted in_valid to out_valid; one result per cycle.
// Backpressure: none; the consumer must take the result in its out_valid cycle.

// One bit of the borrow chain: difference bit and borrow into the next cell.
module full_subtractor_cell (
   input  logic x,
   input  logic y,
   input  logic bin,
   output logic d,
   output logic bout
);
   assign d    = x ^ y ^ bin;
   // Borrow when x < y outright, or when x == y and a borrow arrives from below.
   assign bout = (~x & y) | (~(x ^ y) & bin);
endmodule

module full_subtractor #(
   parameter int WIDTH = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   full_subtractor_if.slave   sub
);
   // b[0] is the external borrow-in; b[WIDTH] leaves the MSB cell.
   logic [WIDTH:0]   b;
   logic [WIDTH-1:0] d;

   logic [WIDTH-1:0] diff_q;
   logic             borr_q;
   logic             valid_q;

   assign b[0] = sub.Z;

   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      full_subtractor_cell u_cell (
         .x    (sub.X[i]),
         .y    (sub.Y[i]),
         .bin  (b[i]),
         .d    (d[i]),
         .bout (b[i+1])
      );
   end

   // Capture the result only for accepted operations; otherwise hold it and drop valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         diff_q  <= '0;
         borr_q  <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         valid_q <= sub.in_valid;
         if (sub.in_valid) begin
            diff_q <= d;
            borr_q <= b[WIDTH];
         end
      end
   end

   assign sub.Diff      = diff_q;
   assign sub.Borr      = borr_q;
   assign sub.out_valid = valid_q;
endmodule

// File: tb/tb_full_subtractor.sv
// Directed bench for full_subtractor at WIDTH=1 and WIDTH=8 plus a random stream.
// Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
// Expected values are hand-computed constants or a 9-bit subtraction model.
module tb_full_subtractor;
   logic clk;
   logic rst_n;

   int n_cmp = 0;
   int n_err = 0;

   full_subtractor_if #(.WIDTH(1)) i1 ();
   full_subtractor_if #(.WIDTH(8)) i8 ();

   full_subtractor #(.WIDTH(1)) u1 (.clk(clk), .rst_n(rst_n), .sub(i1.slave));
   full_subtractor #(.WIDTH(8)) u8 (.clk(clk), .rst_n(rst_n), .sub(i8.slave));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] obs8();
      return 64'({i8.out_valid, i8.Borr, i8.Diff});
   endfunction

   // One accepted WIDTH=8 operation, checked one edge later.
   task automatic step8(input string tag, input logic [7:0] x, input logic [7:0] y,
                        input logic z, input logic [7:0] ed, input logic eb);
      @(negedge clk);
      i8.in_valid = 1'b1;
      i8.X = x;
      i8.Y = y;
      i8.Z = z;
      @(posedge clk);
      #1;
      chk(tag, obs8(), 64'({1'b1, eb, ed}));
   endtask

   // WIDTH=1 truth table, indexed by {X,Y,Z}, giving {Borr,Diff}.
   logic [1:0] tt [0:7];

   initial begin
      logic [2:0] v3;
      logic [7:0] rx, ry;
      logic       rz;
      logic [8:0] r;

      tt[0] = 2'b00; tt[1] = 2'b11; tt[2] = 2'b11; tt[3] = 2'b10;
      tt[4] = 2'b01; tt[5] = 2'b00; tt[6] = 2'b00; tt[7] = 2'b11;

      rst_n = 1'b0;
      i1.in_valid = 1'b0; i1.X = 1'b0; i1.Y = 1'b0; i1.Z = 1'b0;
      i8.in_valid = 1'b0; i8.X = 8'h00; i8.Y = 8'h00; i8.Z = 1'b0;

      #2;
      chk("reset_w1", 64'({i1.out_valid, i1.Borr, i1.Diff}), 64'd0);
      chk("reset_w8", obs8(), 64'd0);

      @(negedge clk);
      rst_n = 1'b1;

      // Exhaustive WIDTH=1, back-to-back.
      for (int v = 0; v < 8; v++) begin
         v3 = 3'(v);
         @(negedge clk);
         i1.in_valid = 1'b1;
         i1.X = v3[2];
         i1.Y = v3[1];
         i1.Z = v3[0];
         @(posedge clk);
         #1;
         chk($sformatf("w1_tt%0d", v), 64'({i1.out_valid, i1.Borr, i1.Diff}), 64'({1'b1, tt[v]}));
      end
      @(negedge clk);
      i1.in_valid = 1'b0;
      i1.X = 1'b0; i1.Y = 1'b1; i1.Z = 1'b0;
      @(posedge clk);
      #1;
      chk("w1_idle_hold", 64'({i1.out_valid, i1.Borr, i1.Diff}), 64'({1'b0, 2'b11}));

      // WIDTH=8 directed vectors, back-to-back.
      step8("w8_eq_nob",   8'h10, 8'h10, 1'b0, 8'h00, 1'b0);
      step8("w8_a5_25",    8'hA5, 8'h25, 1'b0, 8'h80, 1'b0);
      step8("w8_max_zero", 8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0);
      step8("w8_lt",       8'h03, 8'h05, 1'b0, 8'hFE, 1'b1);
      step8("w8_wrap",     8'h00, 8'h00, 1'b1, 8'hFF, 1'b1);

      // Idle: garbage inputs must be ignored and the last result held.
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         i8.in_valid = 1'b0;
         i8.X = 8'h3C;
         i8.Y = 8'h01;
         i8.Z = 1'b0;
         @(posedge clk);
         #1;
         chk($sformatf("w8_idle_hold%0d", k), obs8(), 64'({1'b0, 1'b1, 8'hFF}));
      end

      // Random back-to-back stream.
      for (int k = 0; k < 256; k++) begin
         rx = 8'($urandom);
         ry = 8'($urandom);
         rz = 1'($urandom);
         r  = {1'b0, rx} - {1'b0, ry} - {8'h00, rz};
         @(negedge clk);
         i8.in_valid = 1'b1;
         i8.X = rx;
         i8.Y = ry;
         i8.Z = rz;
         @(posedge clk);
         #1;
         chk($sformatf("w8_stream%0d", k), obs8(), 64'({1'b1, r}));
      end

      // Mid-cycle reset while an operation is in flight and in_valid stays high.
      step8("w8_pre_rst", 8'hA5, 8'h25, 1'b0, 8'h80, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_w8", obs8(), 64'd0);
      chk("async_rst_w1", 64'({i1.out_valid, i1.Borr, i1.Diff}), 64'd0);
      @(posedge clk);
      #1;
      chk("rst_held_w8", obs8(), 64'd0);
      @(negedge clk);
      i8.in_valid = 1'b0;
      rst_n = 1'b1;
      for (int k = 0; k < 2; k++) begin
         @(posedge clk);
         #1;
         chk($sformatf("post_rst%0d", k), obs8(), 64'd0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
